addsub_arbiter_8bit: RTL and testbench
======================================

# addsub_arbiter_8bit

Shares one 8-bit two's-complement adder/subtractor between two requesters, each with a valid/ready request channel and a valid/ready response channel. A round-robin arbiter grants one request at a time, latches its operands, executes one registered operation and returns result, signed overflow and carry to the granted requester. It sits between the datapath clients and the arithmetic core, so the core is never driven by more than one client at a time.

## Interface
- RR_INIT, 0, requester (0 or 1) that holds priority after reset.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; at most one bit high.
- req0_a, req0_b  input  8  requester 0 operands.
- req0_mode  input  1  requester 0 operation: 0 = a+b, 1 = a-b.
- req1_a, req1_b, req1_mode  input  8/8/1  requester 1 operands and mode.
- rsp_valid  output  2  one-hot response valid to the owning requester.
- rsp_ready  input  2  per-requester response accept.
- rsp_result  output  8  shared result bus; meaningful only when any rsp_valid bit is high.
- rsp_ovfl  output  1  signed overflow of the operation.
- rsp_carry  output  1  carry out of a + b (add) or a + ~b + 1 (sub); for sub, 1 means no borrow.
- busy  output  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, arbitration:
  - If only one req_valid bit is high, that requester is selected.
  - If both are high, the requester named by the priority pointer is selected.
  - req_ready[sel] is driven combinationally high. A handshake (valid & ready) latches a, b, mode and the grant index, then the FSM moves to EXEC.
  - With no valid request, the FSM stays in IDLE.
- EXEC: the latched operands drive addsub_core_8bit. result, ovfl and carry are registered. Next state is RESP.
- RESP:
  - rsp_valid[grant] is high. Result, ovfl and carry stay stable until rsp_ready[grant].
  - On that handshake: the FSM returns to IDLE, rsp_valid drops, and the priority pointer is set to the requester that was not granted.
  - rsp_ready of the non-granted requester is ignored.
- Arithmetic, all values mod 256:
  - add: result = a+b; ovfl = (a[7]==b[7]) && (result[7]!=a[7]).
  - sub: result = a + ~b + 1; ovfl = (a[7]!=b[7]) && (result[7]!=a[7]).
  - The sub formula must be used for sub, including b = 0x80. Deriving overflow from the negated b gives the wrong answer for b = 0x80 and is not acceptable.
- Request operands may change freely outside the accept cycle. The block never rereads them after accept.

## Timing
- Reset state, forced in the cycle rst is high: state IDLE, req_ready = 0, rsp_valid = 0, rsp_result = 0x00, rsp_ovfl = 0, rsp_carry = 0, busy = 0, priority pointer = RR_INIT.
- Latency: accept in cycle N, rsp_valid high from cycle N+2.
- Minimum occupancy is 3 cycles per operation. A new accept can occur at the earliest in the cycle after the response handshake.
- req_ready depends combinationally on req_valid and state. A requester must not make req_valid depend on req_ready.
- Response backpressure: the FSM stays in RESP indefinitely. No request is accepted while busy.
- Simultaneous requests: exactly one is accepted per IDLE cycle. The loser keeps valid high and is served next, because the pointer flips.
- A single requester repeatedly requesting alone is served every time, irrespective of the pointer.
- Reset mid-operation (EXEC or RESP): the pending operation is discarded and no response is ever produced for it. The next cycle behaves as after reset.

## Structure
- Package addsub_pkg holds:
  - data width constant 8;
  - MODE_ADD = 1'b0 and MODE_SUB = 1'b1;
  - the FSM state enum {IDLE, EXEC, RESP}.
- Sub-module addsub_core_8bit is purely combinational. It takes a, b and mode and produces result, ovfl and carry. It is instantiated once, holds no state and is reusable elsewhere.
- The arbiter, FSM, operand latches and response registers live in the top module.

## Test plan
- Requester 0 only, add 0x05+0x03 → rsp_valid = 2'b01 two cycles after accept; result 0x08, ovfl 0, carry 0.
- Sub 0x00−0x80 → result 0x80, ovfl 1, carry 0. Sub 0x05−0x00 → result 0x05, ovfl 0, carry 1.
- Add 0x7F+0x01 → result 0x80, ovfl 1, carry 0. Add 0x80+0x80 → result 0x00, ovfl 1, carry 1.
- Both requesters valid continuously from reset with RR_INIT = 0 → responses are served in the order 0, 1, 0, 1. req_ready never has two bits set.
- Hold rsp_ready low for 5 cycles in RESP → result, ovfl and carry stay stable, busy = 1, and req_ready = 0 for the other requester throughout.
- Assert rst for one cycle while in EXEC → rsp_valid is never raised for that operation. A fresh request is accepted in the first cycle after rst falls.

Source files
------------

// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : addsub_pkg
// Description : Shared width, operation-mode and FSM state definitions for the
//               shared 8-bit adder/subtractor arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package addsub_pkg;

    localparam int unsigned c_DATA_W = 8;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : addsub_pkg
`default_nettype wire

// File: rtl/addsub_arbiter_8bit_if.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arbiter_8bit_if
// Description : Two-requester request/response bus of the shared add/sub unit.
//               master = requester side, slave = arbiter side.
// Revision    : 1.0  initial release
// ============================================================================
interface addsub_arbiter_8bit_if;
    import addsub_pkg::*;

    logic [1:0]          req_valid;
    logic [1:0]          req_ready;
    logic [c_DATA_W-1:0] req0_a;
    logic [c_DATA_W-1:0] req0_b;
    logic                req0_mode;
    logic [c_DATA_W-1:0] req1_a;
    logic [c_DATA_W-1:0] req1_b;
    logic                req1_mode;
    logic [1:0]          rsp_valid;
    logic [1:0]          rsp_ready;
    logic [c_DATA_W-1:0] rsp_result;
    logic                rsp_ovfl;
    logic                rsp_carry;
    logic                busy;

    modport master (
        output req_valid, req0_a, req0_b, req0_mode,
               req1_a, req1_b, req1_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_ovfl, rsp_carry, busy
    );

    modport slave (
        input  req_valid, req0_a, req0_b, req0_mode,
               req1_a, req1_b, req1_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_ovfl, rsp_carry, busy
    );

endinterface : addsub_arbiter_8bit_if
`default_nettype wire

// File: rtl/addsub_core_8bit.sv
`default_nettype none
// ============================================================================
// Module      : addsub_core_8bit
// Description : Stateless two's-complement adder/subtractor with signed
//               overflow and carry-out (carry = no-borrow for subtraction).
// Revision    : 1.0  initial release
// ============================================================================
module addsub_core_8bit
    import addsub_pkg::*;
(
    input  wire logic [c_DATA_W-1:0] i_a,
    input  wire logic [c_DATA_W-1:0] i_b,
    input  wire logic                i_mode,
    output logic      [c_DATA_W-1:0] o_result,
    output logic                     o_ovfl,
    output logic                     o_carry
);

    logic                w_is_sub;
    logic [c_DATA_W-1:0] w_b_op;
    logic [c_DATA_W:0]   w_sum;

    assign w_is_sub = (i_mode == MODE_SUB);
    assign w_b_op   = w_is_sub ? ~i_b : i_b;
    assign w_sum    = {1'b0, i_a} + {1'b0, w_b_op} + {{c_DATA_W{1'b0}}, w_is_sub};

    assign o_result = w_sum[c_DATA_W-1:0];
    assign o_carry  = w_sum[c_DATA_W];

    // Overflow is judged on the original b so that b = 0x80 under subtraction
    // is handled correctly (its negation is not representable).
    always_comb begin
        if (w_is_sub) begin
            o_ovfl = (i_a[c_DATA_W-1] != i_b[c_DATA_W-1]) &&
                     (o_result[c_DATA_W-1] != i_a[c_DATA_W-1]);
        end else begin
            o_ovfl = (i_a[c_DATA_W-1] == i_b[c_DATA_W-1]) &&
                     (o_result[c_DATA_W-1] != i_a[c_DATA_W-1]);
        end
    end

endmodule : addsub_core_8bit
`default_nettype wire

// File: rtl/addsub_arbiter_8bit.sv
`default_nettype none
// ============================================================================
// Module      : addsub_arbiter_8bit
// Description : Round-robin arbiter sharing one registered add/sub operation
//               between two valid/ready requesters.
// Revision    : 1.0  initial release
// ============================================================================
module addsub_arbiter_8bit
    import addsub_pkg::*;
#(
    parameter int unsigned RR_INIT = 0
)(
    input  wire logic            clk,
    input  wire logic            rst,
    addsub_arbiter_8bit_if.slave bus
);

    localparam logic c_PTR_INIT = RR_INIT[0];

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_ptr;
    logic                r_grant;
    logic [c_DATA_W-1:0] r_a;
    logic [c_DATA_W-1:0] r_b;
    logic                r_mode;
    logic [c_DATA_W-1:0] r_result;
    logic                r_ovfl;
    logic                r_carry;

    logic                w_sel;
    logic                w_accept;
    logic                w_rsp_done;
    logic [1:0]          w_req_ready;
    logic [1:0]          w_rsp_valid;
    logic [c_DATA_W-1:0] w_core_result;
    logic                w_core_ovfl;
    logic                w_core_carry;

    // A lone requester wins regardless of the pointer.
    always_comb begin
        case (bus.req_valid)
            2'b01:   w_sel = 1'b0;
            2'b10:   w_sel = 1'b1;
            default: w_sel = r_ptr;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req_ready = 2'b00;
        w_rsp_valid = 2'b00;
        w_accept    = 1'b0;
        w_rsp_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|bus.req_valid) begin
                    w_req_ready = w_sel ? 2'b10 : 2'b01;
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                w_rsp_valid = r_grant ? 2'b10 : 2'b01;
                if (bus.rsp_ready[r_grant]) begin
                    w_rsp_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= c_PTR_INIT;
            r_grant  <= 1'b0;
            r_a      <= '0;
            r_b      <= '0;
            r_mode   <= MODE_ADD;
            r_result <= '0;
            r_ovfl   <= 1'b0;
            r_carry  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_grant <= w_sel;
                r_a     <= w_sel ? bus.req1_a    : bus.req0_a;
                r_b     <= w_sel ? bus.req1_b    : bus.req0_b;
                r_mode  <= w_sel ? bus.req1_mode : bus.req0_mode;
            end
            if (r_state == EXEC) begin
                r_result <= w_core_result;
                r_ovfl   <= w_core_ovfl;
                r_carry  <= w_core_carry;
            end
            if (w_rsp_done) begin
                r_ptr <= ~r_grant;
            end
        end
    end

    addsub_core_8bit u_core (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_mode   (r_mode),
        .o_result (w_core_result),
        .o_ovfl   (w_core_ovfl),
        .o_carry  (w_core_carry)
    );

    // Outputs read as reset values during the cycle rst is asserted.
    assign bus.req_ready  = rst ? 2'b00 : w_req_ready;
    assign bus.rsp_valid  = rst ? 2'b00 : w_rsp_valid;
    assign bus.rsp_result = rst ? '0    : r_result;
    assign bus.rsp_ovfl   = rst ? 1'b0  : r_ovfl;
    assign bus.rsp_carry  = rst ? 1'b0  : r_carry;
    assign bus.busy       = rst ? 1'b0  : (r_state != IDLE);

endmodule : addsub_arbiter_8bit
`default_nettype wire

// File: tb/tb_addsub_arbiter_8bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_addsub_arbiter_8bit
// Description : Self-checking bench: vector table, random ops against an
//               arithmetic reference, arbitration/backpressure/reset sequences.
// Revision    : 1.0  initial release
// ============================================================================
module tb_addsub_arbiter_8bit;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    addsub_arbiter_8bit_if bus ();

    addsub_arbiter_8bit #(.RR_INIT(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int unsigned req;
        bit          mode;
        bit [7:0]    a;
        bit [7:0]    b;
        bit [7:0]    res;
        bit          ov;
        bit          cy;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference computed from signed/unsigned integer arithmetic.
    function automatic void model(input bit mode, input bit [7:0] a, input bit [7:0] b,
                                  output bit [7:0] res, output bit ov, output bit cy);
        int sa;
        int sb;
        int sv;
        int uv;
        sa = $signed(a);
        sb = $signed(b);
        if (!mode) begin
            uv = int'(a) + int'(b);
            sv = sa + sb;
            cy = (uv > 255);
        end else begin
            uv = int'(a) - int'(b);
            sv = sa - sb;
            cy = (a >= b);
        end
        res = uv[7:0];
        ov  = (sv > 127) || (sv < -128);
    endfunction

    task automatic set_req(input int unsigned r, input bit [7:0] a, input bit [7:0] b, input bit m);
        if (r == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_mode = m;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_mode = m;
        end
    endtask

    task automatic scramble();
        bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom); bus.req0_mode = 1'($urandom);
        bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom); bus.req1_mode = 1'($urandom);
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 back in IDLE.
    task automatic do_op(input string name, input int unsigned r, input bit m,
                         input bit [7:0] a, input bit [7:0] b,
                         input bit [7:0] eres, input bit eov, input bit ecy);
        bit got;
        logic [1:0] onehot;
        onehot = (r == 0) ? 2'b01 : 2'b10;
        set_req(r, a, b, m);
        bus.req_valid = onehot;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.req_ready == onehot) got = 1'b1;
            else begin @(posedge clk); #1; end
        end
        check({name, " accept"}, 32'(got), 32'd1);
        if (!got) begin
            bus.req_valid = 2'b00;
            return;
        end
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        scramble();
        @(negedge clk);
        check({name, " exec rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check({name, " rsp_valid"}, 32'(bus.rsp_valid), 32'(onehot));
        check({name, " result"},    32'(bus.rsp_result), 32'(eres));
        check({name, " ovfl"},      32'(bus.rsp_ovfl),   32'(eov));
        check({name, " carry"},     32'(bus.rsp_carry),  32'(ecy));
        bus.rsp_ready = onehot;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        check({name, " idle busy"}, 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit [7:0]    er;
        bit          eo;
        bit          ec;
        int unsigned order[$];
        bit          multi;
        bit          stray;

        vecs[0] = '{0, 1'b0, 8'h05, 8'h03, 8'h08, 1'b0, 1'b0};
        vecs[1] = '{1, 1'b1, 8'h00, 8'h80, 8'h80, 1'b1, 1'b0};
        vecs[2] = '{0, 1'b1, 8'h05, 8'h00, 8'h05, 1'b0, 1'b1};
        vecs[3] = '{1, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b1, 1'b0};
        vecs[4] = '{0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{1, 1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{0, 1'b1, 8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0};
        vecs[7] = '{1, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b1};
        vecs[8] = '{0, 1'b1, 8'h80, 8'h80, 8'h00, 1'b0, 1'b1};
        vecs[9] = '{1, 1'b1, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0};

        // Both requesters valid straight out of reset.
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(1, 8'h09, 8'h04, 1'b1);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        @(posedge clk); #1;
        @(negedge clk);
        check("reset req_ready", 32'(bus.req_ready),  32'd0);
        check("reset rsp_valid", 32'(bus.rsp_valid),  32'd0);
        check("reset result",    32'(bus.rsp_result), 32'd0);
        check("reset ovfl",      32'(bus.rsp_ovfl),   32'd0);
        check("reset carry",     32'(bus.rsp_carry),  32'd0);
        check("reset busy",      32'(bus.busy),       32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        multi = 1'b0;
        for (int k = 0; k < 40 && order.size() < 4; k++) begin
            @(negedge clk);
            if (bus.req_ready == 2'b11) multi = 1'b1;
            if (bus.rsp_valid != 2'b00) order.push_back(bus.rsp_valid[1] ? 1 : 0);
            @(posedge clk); #1;
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        check("rr response count", 32'(order.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr order[%0d]", i),
                  (i < order.size()) ? 32'(order[i]) : 32'hFFFF_FFFF, 32'(i % 2));
        end
        check("rr single grant", 32'(multi), 32'd0);

        for (int i = 0; i < 10; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].req, vecs[i].mode, vecs[i].a, vecs[i].b,
                  vecs[i].res, vecs[i].ov, vecs[i].cy);
        end

        for (int i = 0; i < 30; i++) begin
            int unsigned r;
            bit          m;
            bit [7:0]    a;
            bit [7:0]    b;
            r = $urandom_range(0, 1);
            m = 1'($urandom);
            a = 8'($urandom);
            b = 8'($urandom);
            model(m, a, b, er, eo, ec);
            do_op($sformatf("rand%0d", i), r, m, a, b, er, eo, ec);
        end

        // Backpressure on requester 0 while requester 1 waits.
        set_req(0, 8'h7F, 8'h01, 1'b0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("bp accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b10;
        set_req(1, 8'h10, 8'h20, 1'b0);
        bus.rsp_ready = 2'b10;
        @(negedge clk);
        check("bp exec req_ready", 32'(bus.req_ready), 32'd0);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp rsp_valid", 32'(bus.rsp_valid),  32'd1);
            check("bp result",    32'(bus.rsp_result), 32'h80);
            check("bp ovfl",      32'(bus.rsp_ovfl),   32'd1);
            check("bp carry",     32'(bus.rsp_carry),  32'd0);
            check("bp busy",      32'(bus.busy),       32'd1);
            check("bp req_ready", 32'(bus.req_ready),  32'd0);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 2'b01;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        check("bp loser served", 32'(bus.req_ready), 32'd2);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        scramble();
        @(posedge clk); #1;
        @(negedge clk);
        check("bp r1 rsp_valid", 32'(bus.rsp_valid),  32'd2);
        check("bp r1 result",    32'(bus.rsp_result), 32'h30);
        bus.rsp_ready = 2'b10;
        @(posedge clk); #1;
        bus.rsp_ready = 2'b00;

        // Reset while the accepted operation is in EXEC.
        set_req(0, 8'h01, 8'h02, 1'b0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        check("rst accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        check("rst exec rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst exec busy",      32'(bus.busy),      32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        set_req(1, 8'h09, 8'h04, 1'b1);
        bus.req_valid = 2'b10;
        @(negedge clk);
        check("post-rst accept",    32'(bus.req_ready), 32'd2);
        check("post-rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk);
        check("post-rst exec rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("post-rst rsp_valid r1", 32'(bus.rsp_valid),  32'd2);
        check("post-rst result",       32'(bus.rsp_result), 32'h05);
        check("post-rst carry",        32'(bus.rsp_carry),  32'd1);
        bus.rsp_ready = 2'b11;
        @(posedge clk); #1;
        stray = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.rsp_valid != 2'b00) stray = 1'b1;
            @(posedge clk); #1;
        end
        bus.rsp_ready = 2'b00;
        check("discarded op no response", 32'(stray), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_addsub_arbiter_8bit
`default_nettype wire
